// File: rtl/nv_nvdla_cdp_cvtout_pkg.sv
// Shared CDP cvtout types and helpers: info payload width, arbiter limits,
// source-index width function and the info beat record.
package nv_nvdla_cdp_cvtout_pkg;

  localparam int CVTOUT_INFO_PD_W = 15;
  localparam int CDP_ARB_NREQ_MAX = 8;

  // Source index width; a single requester still carries a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CDP_ARB_SRC_W_MAX = clog2_min1(CDP_ARB_NREQ_MAX);

  typedef struct packed {
    logic [CVTOUT_INFO_PD_W-1:0]  pd;
    logic                         last;
    logic [CDP_ARB_SRC_W_MAX-1:0] src;
  } cvtout_info_t;

endpackage

// File: rtl/nv_nvdla_cdp_dp_cvtout_arb_if.sv
// Requester-side and output-side streams of the cvtout info arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface nv_nvdla_cdp_dp_cvtout_arb_if
  import nv_nvdla_cdp_cvtout_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PD_W  = CVTOUT_INFO_PD_W,
  parameter int SRC_W = clog2_min1(NREQ)
) ();

  logic [NREQ-1:0]      req_vld;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*PD_W-1:0] req_pd;
  logic [NREQ-1:0]      req_rdy;
  logic                 out_vld;
  logic                 out_rdy;
  logic [PD_W-1:0]      out_pd;
  logic                 out_last;
  logic [SRC_W-1:0]     out_src;
  logic                 arb_lock;

  modport slave (
    input  req_vld, req_last, req_pd, out_rdy,
    output req_rdy, out_vld, out_pd, out_last, out_src, arb_lock
  );

  modport master (
    output req_vld, req_last, req_pd, out_rdy,
    input  req_rdy, out_vld, out_pd, out_last, out_src, arb_lock
  );

endinterface

// File: rtl/nv_nvdla_cdp_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after the
// pointer, wrapping modulo NREQ. Returns a one-hot grant and its index.
module nv_nvdla_cdp_rr_pick #(
  parameter int NREQ  = 2,
  parameter int SRC_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [SRC_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [SRC_W-1:0] o_idx
);

  always_comb begin
    logic w_found;
    int   j;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned; otherwise synthesis infers latches.
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[j]) begin
        w_found  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_cdp_dp_cvtout_arb.sv
// Round-robin, packet-locked arbiter feeding one registered cvtout info stage.
// Optional stall counters are built when NV_NVDLA_CDP_CVTOUT_ARB_PERF_EN is defined.
module nv_nvdla_cdp_dp_cvtout_arb
  import nv_nvdla_cdp_cvtout_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PD_W  = CVTOUT_INFO_PD_W,
  parameter int SRC_W = clog2_min1(NREQ)
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  nv_nvdla_cdp_dp_cvtout_arb_if.slave   bus
`ifdef NV_NVDLA_CDP_CVTOUT_ARB_PERF_EN
  ,
  input  logic                          perf_clr,
  output logic [NREQ*32-1:0]            perf_stall_cnt
`endif
);

  logic             r_out_vld;
  logic [PD_W-1:0]  r_out_pd;
  logic             r_out_last;
  logic [SRC_W-1:0] r_out_src;
  logic             r_arb_lock;
  logic [SRC_W-1:0] r_lock_id;
  logic [SRC_W-1:0] r_rr_ptr;

  logic             w_ready_bc;
  logic [NREQ-1:0]  w_rr_gnt;
  logic [SRC_W-1:0] w_rr_idx;
  logic [NREQ-1:0]  w_lock_oh;
  logic [NREQ-1:0]  w_gnt;
  logic [SRC_W-1:0] w_gnt_idx;
  logic             w_xfer;
  logic [PD_W-1:0]  w_sel_pd;
  logic             w_sel_last;
  logic [SRC_W-1:0] w_next_ptr;

  assign w_ready_bc = bus.out_rdy | ~r_out_vld;

  nv_nvdla_cdp_rr_pick #(
    .NREQ  (NREQ),
    .SRC_W (SRC_W)
  ) u_rr_pick (
    .i_req (bus.req_vld),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx)
  );

  // While locked only the owner may be granted, even if it is idle.
  assign w_lock_oh = NREQ'(1) << r_lock_id;
  assign w_gnt     = r_arb_lock ? (w_lock_oh & bus.req_vld) : w_rr_gnt;
  assign w_gnt_idx = r_arb_lock ? r_lock_id : w_rr_idx;

  assign bus.req_rdy = w_gnt & {NREQ{w_ready_bc & ~nvdla_core_rst}};
  assign w_xfer      = |(bus.req_vld & bus.req_rdy);

  assign w_sel_pd   = bus.req_pd[int'(w_gnt_idx)*PD_W +: PD_W];
  assign w_sel_last = bus.req_last[w_gnt_idx];
  assign w_next_ptr = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_out_vld  <= 1'b0;
      r_out_pd   <= '0;
      r_out_last <= 1'b0;
      r_out_src  <= '0;
      r_arb_lock <= 1'b0;
      r_lock_id  <= '0;
      r_rr_ptr   <= '0;
    end else if (w_ready_bc) begin
      r_out_vld <= w_xfer;
      if (w_xfer) begin
        r_out_pd   <= w_sel_pd;
        r_out_last <= w_sel_last;
        r_out_src  <= w_gnt_idx;
        if (w_sel_last) begin
          r_arb_lock <= 1'b0;
          r_rr_ptr   <= w_next_ptr;
        end else begin
          r_arb_lock <= 1'b1;
          r_lock_id  <= w_gnt_idx;
        end
      end
    end
  end

  assign bus.out_vld  = r_out_vld;
  assign bus.out_pd   = r_out_pd;
  assign bus.out_last = r_out_last;
  assign bus.out_src  = r_out_src;
  assign bus.arb_lock = r_arb_lock;

`ifdef NV_NVDLA_CDP_CVTOUT_ARB_PERF_EN
  // Per-requester stall counters: waiting with valid but not granted.
  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    logic [31:0] r_cnt;
    always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst || perf_clr) begin
        r_cnt <= '0;
      end else if (bus.req_vld[g] && !bus.req_rdy[g] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign perf_stall_cnt[g*32 +: 32] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_nv_nvdla_cdp_dp_cvtout_arb.sv
// Directed, table-driven bench for the cvtout info arbiter (NREQ=2) with
// hand-written reset-mid-packet and stall-counter sequences.
module tb_nv_nvdla_cdp_dp_cvtout_arb;
  import nv_nvdla_cdp_cvtout_pkg::*;

  localparam int NREQ  = 2;
  localparam int PD_W  = 15;
  localparam int SRC_W = 1;

  typedef struct {
    string        name;
    logic         rst;
    logic [1:0]   vld;
    logic [1:0]   last;
    logic [14:0]  pd0;
    logic [14:0]  pd1;
    logic         ordy;
    logic [1:0]   erdy;
    logic         evld;
    cvtout_info_t ebeat;
    logic         elock;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  nv_nvdla_cdp_dp_cvtout_arb_if #(.NREQ(NREQ), .PD_W(PD_W), .SRC_W(SRC_W)) bus_if ();

`ifdef NV_NVDLA_CDP_CVTOUT_ARB_PERF_EN
  logic                 perf_clr = 1'b0;
  logic [NREQ*32-1:0]   perf_stall_cnt;
`endif

  nv_nvdla_cdp_dp_cvtout_arb #(.NREQ(NREQ), .PD_W(PD_W), .SRC_W(SRC_W)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus_if)
`ifdef NV_NVDLA_CDP_CVTOUT_ARB_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic r, input logic [1:0] vld,
                              input logic [1:0] last, input logic [14:0] pd0,
                              input logic [14:0] pd1, input logic ordy,
                              input logic [1:0] erdy, input logic evld,
                              input logic [14:0] epd, input logic elast,
                              input logic esrc, input logic elock);
    vec_t v;
    v.name  = name;  v.rst  = r;    v.vld = vld;  v.last = last;
    v.pd0   = pd0;   v.pd1  = pd1;  v.ordy = ordy;
    v.erdy  = erdy;  v.evld = evld; v.elock = elock;
    v.ebeat = '{pd: epd, last: elast, src: {2'b00, esrc}};
    return v;
  endfunction

  // Drive one cycle of inputs, check ready before the edge, outputs after it.
  task automatic apply(input vec_t v);
    cvtout_info_t act;
    rst             = v.rst;
    bus_if.req_vld  = v.vld;
    bus_if.req_last = v.last;
    bus_if.req_pd   = {v.pd1, v.pd0};
    bus_if.out_rdy  = v.ordy;
    #1;
    check({v.name, ".req_rdy"}, 32'(bus_if.req_rdy), 32'(v.erdy));
    @(posedge clk);
    #1;
    act = '{pd: bus_if.out_pd, last: bus_if.out_last, src: {2'b00, bus_if.out_src}};
    check({v.name, ".out_vld"},  32'(bus_if.out_vld),  32'(v.evld));
    check({v.name, ".out_pd"},   32'(act.pd),          32'(v.ebeat.pd));
    check({v.name, ".out_last"}, 32'(act.last),        32'(v.ebeat.last));
    check({v.name, ".out_src"},  32'(act.src),         32'(v.ebeat.src));
    check({v.name, ".arb_lock"}, 32'(bus_if.arb_lock), 32'(v.elock));
  endtask

  initial begin
    //                 name       rst vld    last   pd0     pd1     ordy erdy  evld epd     elast esrc elock
    vecs.push_back(mk("rst0",     1, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b00, 0, 15'h000, 0, 0, 0));
    vecs.push_back(mk("rst1",     1, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b00, 0, 15'h000, 0, 0, 0));
    vecs.push_back(mk("fair0",    0, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b01, 1, 15'h0AA, 1, 0, 0));
    vecs.push_back(mk("fair1",    0, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b10, 1, 15'h155, 1, 1, 0));
    vecs.push_back(mk("fair2",    0, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b01, 1, 15'h0AA, 1, 0, 0));
    vecs.push_back(mk("fair3",    0, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b10, 1, 15'h155, 1, 1, 0));
    vecs.push_back(mk("solo0",    0, 2'b01, 2'b11, 15'h0AA, 15'h155, 1, 2'b01, 1, 15'h0AA, 1, 0, 0));
    vecs.push_back(mk("lock_b1",  0, 2'b11, 2'b01, 15'h0AA, 15'h001, 1, 2'b10, 1, 15'h001, 0, 1, 1));
    vecs.push_back(mk("lock_b2",  0, 2'b11, 2'b01, 15'h0AA, 15'h002, 1, 2'b10, 1, 15'h002, 0, 1, 1));
    vecs.push_back(mk("lock_b3",  0, 2'b11, 2'b11, 15'h0AA, 15'h003, 1, 2'b10, 1, 15'h003, 1, 1, 0));
    vecs.push_back(mk("lock_aft", 0, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b01, 1, 15'h0AA, 1, 0, 0));
    vecs.push_back(mk("bp_load",  0, 2'b01, 2'b11, 15'h7FF, 15'h155, 1, 2'b01, 1, 15'h7FF, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk($sformatf("bp_hold%0d", i),
                        0, 2'b11, 2'b11, 15'h0AA, 15'h155, 0, 2'b00, 1, 15'h7FF, 1, 0, 0));
    vecs.push_back(mk("bp_rel",   0, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b10, 1, 15'h155, 1, 1, 0));
    vecs.push_back(mk("gap_lock", 0, 2'b11, 2'b10, 15'h011, 15'h155, 1, 2'b01, 1, 15'h011, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk($sformatf("gap%0d", i),
                        0, 2'b10, 2'b10, 15'h011, 15'h155, 1, 2'b00, 0, 15'h011, 0, 0, 1));
    vecs.push_back(mk("gap_end",  0, 2'b11, 2'b11, 15'h012, 15'h155, 1, 2'b01, 1, 15'h012, 1, 0, 0));
    vecs.push_back(mk("gap_rr",   0, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b10, 1, 15'h155, 1, 1, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset in the middle of a packet owned by requester 1: lock is dropped
    // and the first grant after release goes to requester 0.
    apply(mk("mid_lock", 0, 2'b10, 2'b00, 15'h0AA, 15'h044, 1, 2'b10, 1, 15'h044, 0, 1, 1));
    apply(mk("mid_rst",  1, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b00, 0, 15'h000, 0, 0, 0));
    apply(mk("post_rst", 0, 2'b11, 2'b11, 15'h0AA, 15'h155, 1, 2'b01, 1, 15'h0AA, 1, 0, 0));

`ifdef NV_NVDLA_CDP_CVTOUT_ARB_PERF_EN
    // Load a beat while clearing, then stall requester 1 for 10 cycles.
    perf_clr = 1'b1;
    apply(mk("perf_load", 0, 2'b01, 2'b01, 15'h7FF, 15'h155, 1, 2'b01, 1, 15'h7FF, 1, 0, 0));
    perf_clr = 1'b0;
    for (int i = 0; i < 10; i++)
      apply(mk($sformatf("perf_stall%0d", i),
               0, 2'b10, 2'b01, 15'h7FF, 15'h155, 0, 2'b00, 1, 15'h7FF, 1, 0, 0));
    check("perf_cnt1", perf_stall_cnt[63:32], 32'd10);
    check("perf_cnt0", perf_stall_cnt[31:0],  32'd0);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    check("perf_clr1", perf_stall_cnt[63:32], 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cdp_dp_cvtout_arb.md
Name: nv_nvdla_cdp_dp_cvtout_arb

Overview:
- Round-robin arbiter with packet lock that shares one CDP cvtout info pipe stage among NREQ upstream requesters.
- Produces a single registered valid/ready/pd stream with the same skid-free pipe semantics as the existing cvtout pipe stages: accept when the stage is empty or downstream is ready.
- A grant is held from the first beat of a packet until its last beat, so multi-beat info packets are never interleaved.
- Sits between the per-lane cvtout info producers and the p3 output pipe.

Parameters:
- NREQ, 2, number of requesters (2..8).
- PD_W, 15, payload width per requester.
- SRC_W, 1, source-index width; must equal max(1, ceil(log2(NREQ))).

Ports:
- nvdla_core_clk  in  1  core clock; all state on rising edge.
- nvdla_core_rst  in  1  synchronous, active-high reset.
- req_vld  in  NREQ  per-requester valid.
- req_last  in  NREQ  per-requester last-beat-of-packet flag, qualified by req_vld.
- req_pd  in  NREQ*PD_W  payloads; requester i occupies bits [i*PD_W +: PD_W].
- req_rdy  out  NREQ  per-requester ready; one-hot or zero.
- out_vld  out  1  registered output valid.
- out_rdy  in  1  downstream ready.
- out_pd  out  PD_W  registered payload.
- out_last  out  1  registered last flag.
- out_src  out  SRC_W  registered index of the requester that produced the beat.
- arb_lock  out  1  a packet is in progress and the grant is locked.

Behaviour:
- Reset (synchronous, nvdla_core_rst=1 at a clock edge):
  - out_vld=0, out_pd=0, out_last=0, out_src=0, arb_lock=0.
  - Round-robin pointer rr_ptr=0 and lock owner lock_id=0.
  - req_rdy=0 while reset is asserted.
  - Reset mid-packet discards the lock and any held beat; no beat is delivered from the reset cycle.
- Stage ready: ready_bc = out_rdy | ~out_vld.
- Grant selection (combinational, one-hot gnt):
  - arb_lock=1: gnt = onehot(lock_id) & req_vld.
  - arb_lock=0: gnt = first set req_vld bit searching rr_ptr, rr_ptr+1, ... with wrap modulo NREQ.
- Handshake:
  - req_rdy = gnt & {NREQ{ready_bc}}.
  - A transfer from requester i occurs when req_vld[i] & req_rdy[i].
  - Upstream may hold or change pd while not ready; there is no combinational path from req_vld to req_rdy of other requesters beyond the gnt mux.
- Output register update on each edge:
  - If ready_bc: out_vld <= |(req_vld & gnt); on a transfer, out_pd/out_last/out_src <= the granted requester's fields.
  - Else hold all output registers.
  - Latency is 1 cycle from accepted input to out_vld; throughput is 1 beat/cycle under continuous out_rdy.
- Lock:
  - On a transfer with last=0: arb_lock <= 1, lock_id <= i.
  - On a transfer with last=1: arb_lock <= 0, rr_ptr <= (i+1) mod NREQ.
  - A single-beat packet (last=1 on first beat) never sets the lock but still advances rr_ptr.
  - While locked and the owner's req_vld=0, no requester is granted and the lock holds indefinitely; other requesters wait.
- Boundaries:
  - Backpressure (out_vld=1, out_rdy=0): all req_rdy=0 and the output stays stable.
  - No request: rr_ptr unchanged.
  - NREQ=1 degenerates to a plain pipe stage with out_src=0.
  - Simultaneous out_rdy and a new transfer in the same cycle replace the beat with no bubble.

Optional Feature:
- Macro: NV_NVDLA_CDP_CVTOUT_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [NREQ*32] plus input perf_clr.
  - Counter i increments, saturating at 0xFFFFFFFF, every cycle req_vld[i]=1 and req_rdy[i]=0.
  - perf_clr=1 or reset sets all counters to 0; clear takes priority over increment.
- Undefined: no ports, no counter logic; functional behaviour is identical.

Decomposition:
- Shared package nv_nvdla_cdp_cvtout_pkg holds:
  - CVTOUT_INFO_PD_W=15.
  - CDP_ARB_NREQ_MAX=8.
  - Function clog2_min1 for SRC_W.
  - Typedef for the info beat struct {pd, last, src}.
- One sub-module: nv_nvdla_cdp_rr_pick, a combinational rotate-priority picker with inputs req and ptr and output one-hot gnt plus index. It is reused by other CDP arbiters.

Test Plan:
- Reset: assert nvdla_core_rst for 2 cycles with req_vld=2'b11 -> req_rdy=0, out_vld=0, arb_lock=0; first grant after release goes to requester 0.
- Fairness: NREQ=2, both requesters send continuous single-beat packets (last=1), pd 0x0AA and 0x155, out_rdy=1 -> out_src alternates 0,1,0,1 and no cycle has out_vld=0 after the first.
- Lock: requester 1 sends a 3-beat packet (pd 0x001,0x002,0x003, last on 3rd) while requester 0 is valid throughout -> out_src=1 for three beats, then 0; arb_lock is high after beat 1 and low after beat 3.
- Backpressure: out_rdy=0 for 4 cycles with out_vld=1, out_pd=0x7FF -> output is stable and req_rdy=0; when out_rdy rises, the next beat arrives the following cycle with no bubble.
- Owner gap: locked to requester 0, req_vld[0] drops for 3 cycles while req_vld[1]=1 -> req_rdy[1] stays 0 and arb_lock stays 1.
- Perf (macro defined): hold req_vld[1]=1 with out_rdy=0 for 10 cycles -> perf_stall_cnt[1]=10; pulse perf_clr -> 0.
